datapath_sequencer: RTL
=======================

Name: datapath_sequencer

Overview:
- Command-side controller that drives the register-file/ALU datapath through its write port (WE, W1, Din), read selects (num_R1, num_R2) and ALU mode (MS).
- Splits a two-operand command into two sequential register writes, then one execute cycle, so two operands can be loaded through the single Din port.
- Captures the ALU result and returns it over a valid/ready handshake.
- Sits between the command source (testbench or host) and the datapath.

Parameters:
- size_data, 16, operand/result width; must match the datapath.
- addr_w, 3, register-file address width.
- ms_w, 3, ALU mode-select width.
- cnt_w, 16, width of the completed-operation counter.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_exec_only  in  1  1 = skip operand writes; operate on existing register contents.
- cmd_opa  in  size_data  operand A.
- cmd_opb  in  size_data  operand B.
- cmd_ra  in  addr_w  register for A / first read select.
- cmd_rb  in  addr_w  register for B / second read select.
- cmd_ms  in  ms_w  ALU mode, passed through unmodified.
- dp_we  out  1  to datapath WE.
- dp_w1  out  addr_w  to datapath W1.
- dp_din  out  size_data  to datapath Din.
- dp_r1  out  addr_w  to datapath num_R1.
- dp_r2  out  addr_w  to datapath num_R2.
- dp_ms  out  ms_w  to datapath MS.
- dp_alu_out  in  size_data  from datapath ALU_out (combinational path in the datapath).
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  size_data  captured ALU result.
- op_count  out  cnt_w  number of completed result handshakes.

Behaviour:
- Reset (async, RST=1): state=IDLE; all dp_* outputs=0; res_valid=0; res_data=0; op_count=0; cmd_ready=0 while RST is high.
  - Reset asserted mid-operation aborts the command. No partial result is produced, and no write is issued after RST rises.
- States: IDLE, WR_A, WR_B, EXEC, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch every cmd_* field into internal registers.
  - Next state is WR_A, or EXEC if cmd_exec_only=1.
- WR_A: dp_we=1, dp_w1=ra, dp_din=opa. Next WR_B.
- WR_B: dp_we=1, dp_w1=rb, dp_din=opb. Next EXEC.
- EXEC:
  - dp_we=0, dp_r1=ra, dp_r2=rb, dp_ms=ms.
  - res_data <= dp_alu_out at the closing edge. Next RESP.
- RESP:
  - res_valid=1. res_data is held stable until res_valid&res_ready.
  - On the handshake: op_count+=1 (wraps modulo 2^cnt_w); next IDLE.
- Output timing:
  - All dp_* outputs are registered (Moore): valid for the whole state cycle.
  - dp_we=0 in every state except WR_A and WR_B.
  - dp_r1, dp_r2 and dp_ms hold their last EXEC values outside EXEC.
- cmd_ready is 0 in every state except IDLE. Commands are never overlapped or queued.
- Latency (handshake at edge 0):
  - Full command: writes in cycles 1–2, execute in cycle 3, res_valid=1 from cycle 4.
  - Exec-only: execute in cycle 1, res_valid from cycle 2.
  - Maximum throughput: one full command per 5 cycles, one exec-only command per 3 cycles.
- ra==rb on a full command: the B write overwrites A, so the ALU sees opb on both inputs. This is intended behaviour and not flagged.
- Latched command fields are immune to cmd_* changes after acceptance.
- res_ready held high in advance: RESP lasts exactly one cycle.

Test Plan:
- Bench datapath model: 8x16 register file, MS=0 is add, MS=1 is subtract (R1−R2).
- Full add: ra=1, rb=2, opa=0x0005, opb=0x0003, ms=0, res_ready=1.
  - Cycle 1: dp_we=1, dp_w1=1, dp_din=5. Cycle 2: dp_w1=2, dp_din=3.
  - res_valid in cycle 4 with res_data=0x0008; op_count=1.
- Exec-only subtract after the test above: ra=1, rb=2, ms=1 → no dp_we pulse; res_data=0x0002 two cycles after accept.
- Backpressure: res_ready=0 for 6 cycles in RESP → res_valid and res_data=0x0008 held stable; cmd_ready=0 throughout; on res_ready=1 → IDLE next cycle.
- Same register: ra=rb=4, opa=0x0010, opb=0x0001, ms=0 → res_data=0x0002.
- Reset mid-op: assert RST during WR_B → immediately dp_we=0, res_valid=0, op_count=0; after release, cmd_ready=1 and no stale result appears.
- Wrap: add 0xFFFF+0x0001 → res_data=0x0000. Preload op_count to 0xFFFF via 65535 commands (or a forced value) → the next handshake gives op_count=0.

Source files
------------

// File: rtl/datapath_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// datapath_sequencer : loads two operands through a single write port, then
// executes and returns the ALU result over a valid/ready handshake. Rev 1.0
// ---------------------------------------------------------------------------
module datapath_sequencer #(
  parameter int size_data = 16,
  parameter int addr_w    = 3,
  parameter int ms_w      = 3,
  parameter int cnt_w     = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_exec_only,
  input  logic [size_data-1:0] cmd_opa,
  input  logic [size_data-1:0] cmd_opb,
  input  logic [addr_w-1:0]    cmd_ra,
  input  logic [addr_w-1:0]    cmd_rb,
  input  logic [ms_w-1:0]      cmd_ms,
  output logic                 dp_we,
  output logic [addr_w-1:0]    dp_w1,
  output logic [size_data-1:0] dp_din,
  output logic [addr_w-1:0]    dp_r1,
  output logic [addr_w-1:0]    dp_r2,
  output logic [ms_w-1:0]      dp_ms,
  input  logic [size_data-1:0] dp_alu_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [size_data-1:0] res_data,
  output logic [cnt_w-1:0]     op_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR_A = 3'd1,
    WR_B = 3'd2,
    EXEC = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [addr_w-1:0]    ra_q, ra_d;
  logic [addr_w-1:0]    rb_q, rb_d;
  logic [size_data-1:0] opb_q, opb_d;
  logic [ms_w-1:0]      ms_q, ms_d;

  logic                 we_q, we_d;
  logic [addr_w-1:0]    w1_q, w1_d;
  logic [size_data-1:0] din_q, din_d;
  logic [addr_w-1:0]    r1_q, r1_d;
  logic [addr_w-1:0]    r2_q, r2_d;
  logic [ms_w-1:0]      dpms_q, dpms_d;
  logic [size_data-1:0] res_q, res_d;
  logic [cnt_w-1:0]     cnt_q, cnt_d;

  logic                 accept;

  // Ready is forced low during reset even though the state already reads IDLE.
  assign cmd_ready = (state_q == IDLE) && !RST;
  assign accept    = cmd_valid && cmd_ready;

  // Datapath outputs are computed for the state being entered so they are
  // registered and stable for the whole cycle of that state.
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    opb_d   = opb_q;
    ms_d    = ms_q;
    we_d    = 1'b0;
    w1_d    = w1_q;
    din_d   = din_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    dpms_d  = dpms_q;
    res_d   = res_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          ra_d  = cmd_ra;
          rb_d  = cmd_rb;
          opb_d = cmd_opb;
          ms_d  = cmd_ms;
          if (cmd_exec_only) begin
            state_d = EXEC;
            r1_d    = cmd_ra;
            r2_d    = cmd_rb;
            dpms_d  = cmd_ms;
          end else begin
            state_d = WR_A;
            we_d    = 1'b1;
            w1_d    = cmd_ra;
            din_d   = cmd_opa;
          end
        end
      end
      WR_A: begin
        state_d = WR_B;
        we_d    = 1'b1;
        w1_d    = rb_q;
        din_d   = opb_q;
      end
      WR_B: begin
        state_d = EXEC;
        r1_d    = ra_q;
        r2_d    = rb_q;
        dpms_d  = ms_q;
      end
      EXEC: begin
        state_d = RESP;
        res_d   = dp_alu_out;
      end
      RESP: begin
        if (res_ready) begin
          state_d = IDLE;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      opb_q   <= '0;
      ms_q    <= '0;
      we_q    <= 1'b0;
      w1_q    <= '0;
      din_q   <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      dpms_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      opb_q   <= opb_d;
      ms_q    <= ms_d;
      we_q    <= we_d;
      w1_q    <= w1_d;
      din_q   <= din_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      dpms_q  <= dpms_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dp_we     = we_q;
  assign dp_w1     = w1_q;
  assign dp_din    = din_q;
  assign dp_r1     = r1_q;
  assign dp_r2     = r2_q;
  assign dp_ms     = dpms_q;
  assign res_valid = (state_q == RESP);
  assign res_data  = res_q;
  assign op_count  = cnt_q;

endmodule

`default_nettype wire
